adc128s022_scan_ctrl: RTL and testbench
=======================================

Name: adc128s022_scan_ctrl

Overview:
- Master-side SPI controller for the on-board 8-channel 12-bit ADC128S022.
- Drives ADC_CS_N, ADC_SCLK and ADC_SADDR, and samples ADC_SDAT.
- Scans the channels enabled in a mask round-robin and emits one {channel, 12-bit result} beat per conversion.
- Sits between the top-level ADC pins and downstream consumers (LED bar, GPIO streamers); runs on CLOCK_50.

Parameters:
- HALF_DIV, 12, CLOCK_50 cycles per ADC_SCLK half-period (12 gives 2.083 MHz SCLK); legal range 8..31.
- CHANNELS, 8, number of ADC inputs; fixed at 8, sets the channel_mask width.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  level; 1 = keep scanning, 0 = finish the current frame and stop.
- channel_mask  in  8  bit i = scan channel i; sampled once per frame, at frame start.
- sample_valid  out  1  one-cycle pulse; sample_channel and sample_data are valid in that cycle.
- sample_channel  out  3  channel the result belongs to.
- sample_data  out  12  conversion result, straight binary.
- busy  out  1  high whenever ADC_CS_N is low or the QUIET state is active.
- ADC_CS_N  out  1  ADC chip select, active-low.
- ADC_SCLK  out  1  SPI clock; idles high.
- ADC_SADDR  out  1  MOSI; carries the channel address.
- ADC_SDAT  in  1  MISO from the ADC.

Behaviour:
- Reset values:
  - ADC_CS_N=1, ADC_SCLK=1, ADC_SADDR=0.
  - sample_valid=0, sample_channel=0, sample_data=0, busy=0.
  - State IDLE, prev_addr=0, scan pointer=0.
- Reset mid-frame: all outputs return to reset values on the next edge. No partial sample is emitted.
- States:
  - IDLE: leave when enable=1 and channel_mask!=0. Drive CS_N=0, clear prev_addr to 0, go to SETUP.
  - SETUP: wait HALF_DIV cycles with SCLK high, then go to LOW at bit=0.
  - LOW: SCLK=0 for HALF_DIV cycles. On entry (the falling edge), ADC_SADDR = frame word bit (15-bit).
  - HIGH: SCLK=1 for HALF_DIV cycles. On the cycle SCLK goes 0->1, shift ADC_SDAT into the receive register.
  - QUIET: CS_N=1, SCLK=1 for 2*HALF_DIV cycles, then go to IDLE.
- Frame word sent MSB first: bits 13:11 = next address, all other bits 0. Each frame is 16 SCLK periods.
- Receive: bits captured at bit indices 4..15 form sample_data, MSB first. Bits 0..3 are ignored.
- After HIGH of bit 15:
  - If enable=1 and mask!=0: start the next frame at LOW immediately. CS_N stays low and there is no gap.
  - Otherwise go to QUIET.
- Address selection (at frame start):
  - next address = lowest set mask bit at or above the scan pointer, wrapping past 7 to 0.
  - Scan pointer then becomes next address+1 (mod 8).
- Pipelining:
  - The result received in a frame belongs to prev_addr, the address sent in the previous frame (0 for the first frame after CS_N falls).
  - At frame end, prev_addr <= the address just sent.
- Output strobe:
  - sample_valid pulses 1 cycle after the final (16th) SCLK rising edge, only if channel_mask[prev_addr] (mask value at that frame's start) = 1.
  - Otherwise the result is dropped and no pulse is produced.
- Mask changes take effect at the next frame start only. A mask of 0 at a frame boundary ends the scan, like enable=0.
- Cadence: frame period = 32*HALF_DIV cycles (384); at most one sample_valid per frame.

Test Plan:
- Reset held 5 cycles mid-frame -> CS_N=1, SCLK=1, SADDR=0, sample_valid=0, busy=0 within 1 cycle after reset deassertion.
- Bench ADC model returns 12'h0AB + ch*12'h100; mask=8'hFF, enable=1 for 10 frames -> sample_channel sequence 0,0,1,2,3,4,5,6,7,0 with data 0AB,0AB,1AB,…,7AB. First pair: frame 0 reports the default IN0; frame 1 reports address 0. Pulses spaced exactly 384 cycles.
- mask=8'h20 -> SADDR address field always 3'b101. First frame's IN0 result dropped (mask[0]=0); all later beats report channel 5 with data 5AB.
- SCLK timing check -> SCLK high 12 / low 12 cycles; SADDR changes only in cycles where SCLK goes 1->0. CS_N-fall to first SCLK fall = 12 cycles.
- enable dropped at bit 7 of a frame -> that frame completes with sample_valid, then CS_N rises. CS_N high for ≥24 cycles before the next frame; busy=0 after QUIET.
- mask 8'h81->8'h04 changed mid-frame -> the current frame still sends the address chosen at its start. The following frame sends address 2 and the result for address 2 appears one frame later.

Source files
------------

// File: rtl/adc128s022_scan_ctrl.sv
// SPI master for the ADC128S022: round-robin scan of the enabled channels,
// one {channel, 12-bit result} beat per 16-SCLK frame.
module adc128s022_scan_ctrl #(
    parameter int HALF_DIV = 12,
    parameter int CHANNELS = 8
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] channel_mask,
    output logic                sample_valid,
    output logic [2:0]          sample_channel,
    output logic [11:0]         sample_data,
    output logic                busy,
    output logic                ADC_CS_N,
    output logic                ADC_SCLK,
    output logic                ADC_SADDR,
    input  logic                ADC_SDAT
);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, QUIET} state_t;

    localparam logic [5:0] HALF_LAST  = 6'(HALF_DIV - 1);
    localparam logic [5:0] QUIET_LAST = 6'(2 * HALF_DIV - 1);

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                saddr_q, saddr_d;
    logic [11:0]         rx_q, rx_d;
    logic [2:0]          cur_addr_q, cur_addr_d;
    logic [2:0]          prev_addr_q, prev_addr_d;
    logic [2:0]          scan_ptr_q, scan_ptr_d;
    logic [CHANNELS-1:0] frame_mask_q, frame_mask_d;
    logic                sample_valid_q, sample_valid_d;
    logic [2:0]          sample_channel_q, sample_channel_d;
    logic [11:0]         sample_data_q, sample_data_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [2:0]          pick_addr;
    logic [15:0]         frame_word;

    // Lowest enabled channel at or above the scan pointer, wrapping 7 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_addr  = scan_ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!pick_found && channel_mask[scan_ptr_q + 3'(i)]) begin
                pick_found = 1'b1;
                pick_addr  = scan_ptr_q + 3'(i);
            end
        end
    end

    assign frame_word = {2'b00, cur_addr_q, 11'd0};

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        bit_idx_d        = bit_idx_q;
        cs_n_d           = cs_n_q;
        sclk_d           = sclk_q;
        saddr_d          = saddr_q;
        rx_d             = rx_q;
        cur_addr_d       = cur_addr_q;
        prev_addr_d      = prev_addr_q;
        scan_ptr_d       = scan_ptr_q;
        frame_mask_d     = frame_mask_q;
        sample_valid_d   = 1'b0;
        sample_channel_d = sample_channel_q;
        sample_data_d    = sample_data_q;
        busy_d           = busy_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (enable && pick_found) begin
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    prev_addr_d  = 3'd0;
                    cur_addr_d   = pick_addr;
                    scan_ptr_d   = pick_addr + 3'd1;
                    frame_mask_d = channel_mask;
                    cnt_d        = 6'd0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = 6'd0;
                    bit_idx_d = 4'd0;
                    sclk_d    = 1'b0;
                    saddr_d   = frame_word[15];
                    state_d   = LOW;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = 6'd0;
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[10:0], ADC_SDAT};
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            HIGH: begin
                // rx_q holds the last 12 bits one cycle after the 16th rising edge
                if (cnt_q == 6'd0 && bit_idx_q == 4'd15 && frame_mask_q[prev_addr_q]) begin
                    sample_valid_d   = 1'b1;
                    sample_channel_d = prev_addr_q;
                    sample_data_d    = rx_q;
                end
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 6'd0;
                    if (bit_idx_q == 4'd15) begin
                        prev_addr_d = cur_addr_q;
                        if (enable && pick_found) begin
                            cur_addr_d   = pick_addr;
                            scan_ptr_d   = pick_addr + 3'd1;
                            frame_mask_d = channel_mask;
                            bit_idx_d    = 4'd0;
                            sclk_d       = 1'b0;
                            saddr_d      = 1'b0;
                            state_d      = LOW;
                        end else begin
                            cs_n_d  = 1'b1;
                            saddr_d = 1'b0;
                            state_d = QUIET;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        sclk_d    = 1'b0;
                        saddr_d   = frame_word[4'd14 - bit_idx_q];
                        state_d   = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d   = 6'd0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= 6'd0;
            bit_idx_q        <= 4'd0;
            cs_n_q           <= 1'b1;
            sclk_q           <= 1'b1;
            saddr_q          <= 1'b0;
            rx_q             <= 12'd0;
            cur_addr_q       <= 3'd0;
            prev_addr_q      <= 3'd0;
            scan_ptr_q       <= 3'd0;
            frame_mask_q     <= '0;
            sample_valid_q   <= 1'b0;
            sample_channel_q <= 3'd0;
            sample_data_q    <= 12'd0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            bit_idx_q        <= bit_idx_d;
            cs_n_q           <= cs_n_d;
            sclk_q           <= sclk_d;
            saddr_q          <= saddr_d;
            rx_q             <= rx_d;
            cur_addr_q       <= cur_addr_d;
            prev_addr_q      <= prev_addr_d;
            scan_ptr_q       <= scan_ptr_d;
            frame_mask_q     <= frame_mask_d;
            sample_valid_q   <= sample_valid_d;
            sample_channel_q <= sample_channel_d;
            sample_data_q    <= sample_data_d;
            busy_q           <= busy_d;
        end
    end

    assign ADC_CS_N       = cs_n_q;
    assign ADC_SCLK       = sclk_q;
    assign ADC_SADDR      = saddr_q;
    assign sample_valid   = sample_valid_q;
    assign sample_channel = sample_channel_q;
    assign sample_data    = sample_data_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_adc128s022_scan_ctrl.sv
// Directed bench for adc128s022_scan_ctrl with a behavioural ADC128S022 model
// that returns 12'h0AB + ch*12'h100 for the channel addressed one frame earlier.
module tb_adc128s022_scan_ctrl;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  channel_mask = 8'h00;
    logic        sample_valid;
    logic [2:0]  sample_channel;
    logic [11:0] sample_data;
    logic        busy;
    logic        ADC_CS_N;
    logic        ADC_SCLK;
    logic        ADC_SADDR;
    logic        adc_sdat = 1'b0;

    adc128s022_scan_ctrl #(.HALF_DIV(12), .CHANNELS(8)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .enable(enable), .channel_mask(channel_mask),
        .sample_valid(sample_valid), .sample_channel(sample_channel),
        .sample_data(sample_data), .busy(busy), .ADC_CS_N(ADC_CS_N),
        .ADC_SCLK(ADC_SCLK), .ADC_SADDR(ADC_SADDR), .ADC_SDAT(adc_sdat)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // ADC model and pin monitor, sampled on the falling CLOCK_50 edge
    int         cyc = 0, run = 0, rcnt = 0, cs_high_run = 0, last_cs_high = 0;
    int         cs_fall_t = 0, cs_rise_t = 0, last_rise_t = 0;
    int         sclk_bad = 0, saddr_bad = 0;
    bit         have_prev = 1'b0;
    logic       prev_sclk = 1'b1, prev_cs = 1'b1, prev_saddr = 1'b0;
    logic [2:0] addr_cap = 3'd0, conv_ch = 3'd0;
    logic [11:0] adc_w;
    logic [2:0]  samp_ch[$];
    logic [11:0] samp_data[$];
    int          samp_t[$], samp_dr[$];
    logic [2:0]  sent_q[$];

    always @(negedge CLOCK_50) begin
        cyc++;
        run++;
        if (ADC_CS_N) cs_high_run++;
        if (prev_cs && !ADC_CS_N) begin
            conv_ch = 3'd0; rcnt = 0; run = 0; have_prev = 1'b1;
            cs_fall_t = cyc; last_cs_high = cs_high_run; cs_high_run = 0;
        end
        if (ADC_CS_N) begin
            have_prev = 1'b0;
            if (!prev_cs) cs_rise_t = cyc;
        end
        if (!ADC_CS_N && prev_sclk != ADC_SCLK) begin
            if (have_prev && run != 12) sclk_bad++;
            run = 0; have_prev = 1'b1;
        end
        if (!ADC_CS_N && ADC_SADDR != prev_saddr && !(prev_sclk && !ADC_SCLK)) saddr_bad++;
        if (!ADC_CS_N && prev_sclk && !ADC_SCLK) begin
            adc_w = 12'h0AB + 12'({conv_ch, 8'h00});
            adc_sdat = (rcnt >= 4) ? adc_w[15 - rcnt] : 1'b0;
        end
        if (!ADC_CS_N && !prev_sclk && ADC_SCLK) begin
            last_rise_t = cyc;
            if (rcnt >= 2 && rcnt <= 4) addr_cap[4 - rcnt] = ADC_SADDR;
            rcnt++;
            if (rcnt == 16) begin
                rcnt = 0; conv_ch = addr_cap; sent_q.push_back(addr_cap);
            end
        end
        if (sample_valid) begin
            samp_ch.push_back(sample_channel);
            samp_data.push_back(sample_data);
            samp_t.push_back(cyc);
            samp_dr.push_back(cyc - last_rise_t);
        end
        prev_sclk = ADC_SCLK; prev_cs = ADC_CS_N; prev_saddr = ADC_SADDR;
    end

    int passed = 0, total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge CLOCK_50); #1;
    endtask

    task automatic wait_samples(input int n, input int budget);
        int k = 0;
        while (samp_ch.size() < n && k < budget) begin tick(); k++; end
        check("sample_timeout", 32'(samp_ch.size() >= n), 32'd1);
    endtask

    initial begin
        int bs, ba, n, k;
        logic [2:0] ech;

        // reset state
        repeat (3) tick();
        check("rst_cs_n", 32'(ADC_CS_N), 32'd1);
        check("rst_sclk", 32'(ADC_SCLK), 32'd1);
        check("rst_saddr", 32'(ADC_SADDR), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_chan_data", {17'd0, sample_channel, sample_data}, 32'd0);
        rst = 1'b0;

        // full-mask scan, 10 frames
        channel_mask = 8'hFF; enable = 1'b1;
        tick();
        check("start_busy", 32'(busy), 32'd1);
        wait_samples(10, 10 * 400);
        check("ff_first_lat", 32'(samp_t[0] - cs_fall_t), 32'd385);
        check("ff_after_rise", 32'(samp_dr[0]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ech = (i == 0) ? 3'd0 : 3'((i - 1) % 8);
            check("ff_chan", 32'(samp_ch[i]), 32'(ech));
            check("ff_data", 32'(samp_data[i]), 32'(12'h0AB + 12'({ech, 8'h00})));
            check("ff_sent", 32'(sent_q[i]), 32'(i % 8));
            if (i > 0) check("ff_spacing", 32'(samp_t[i] - samp_t[i-1]), 32'd384);
        end

        // reset mid-frame for 5 cycles
        repeat (150) tick();
        n = samp_ch.size();
        rst = 1'b1; enable = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_cs_n", 32'(ADC_CS_N), 32'd1);
        check("mid_rst_sclk", 32'(ADC_SCLK), 32'd1);
        check("mid_rst_saddr", 32'(ADC_SADDR), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_nosample", 32'(samp_ch.size()), 32'(n));

        // single channel 5
        bs = samp_ch.size(); ba = sent_q.size();
        channel_mask = 8'h20; enable = 1'b1;
        wait_samples(bs + 3, 4 * 400);
        check("m20_first_lat", 32'(samp_t[bs] - cs_fall_t), 32'd769);
        for (int i = 0; i < 3; i++) begin
            check("m20_chan", 32'(samp_ch[bs + i]), 32'd5);
            check("m20_data", 32'(samp_data[bs + i]), 32'h5AB);
            check("m20_sent", 32'(sent_q[ba + i]), 32'd5);
        end

        // drop enable at bit 7
        k = 0;
        while (rcnt != 7 && k < 500) begin tick(); k++; end
        check("bit7_reached", 32'(rcnt), 32'd7);
        enable = 1'b0;
        n = samp_ch.size();
        k = 0;
        while (!ADC_CS_N && k < 500) begin tick(); k++; end
        check("stop_cs_high", 32'(ADC_CS_N), 32'd1);
        check("stop_busy_quiet", 32'(busy), 32'd1);
        check("stop_last_sample", 32'(samp_ch.size()), 32'(n + 1));
        check("stop_last_data", 32'(samp_data[n]), 32'h5AB);
        k = 0;
        while (busy && k < 100) begin tick(); k++; end
        check("quiet_len", 32'(cyc - cs_rise_t), 32'd24);
        check("idle_busy", 32'(busy), 32'd0);

        // mask change 81 -> 04 in the middle of a frame
        bs = samp_ch.size(); ba = sent_q.size();
        channel_mask = 8'h81; enable = 1'b1;
        k = 0;
        while (!(rcnt == 8 && !ADC_CS_N && sent_q.size() == ba) && k < 600) begin tick(); k++; end
        check("cs_gap", 32'(last_cs_high >= 24), 32'd1);
        channel_mask = 8'h04;
        wait_samples(bs + 2, 3 * 400);
        check("mc_sent0", 32'(sent_q[ba]), 32'd7);
        check("mc_sent1", 32'(sent_q[ba + 1]), 32'd2);
        check("mc_chan0", 32'(samp_ch[bs]), 32'd0);
        check("mc_data0", 32'(samp_data[bs]), 32'h0AB);
        check("mc_chan1", 32'(samp_ch[bs + 1]), 32'd2);
        check("mc_data1", 32'(samp_data[bs + 1]), 32'h2AB);
        check("mc_gap", 32'(samp_t[bs + 1] - samp_t[bs]), 32'd768);

        enable = 1'b0;
        k = 0;
        while ((busy || !ADC_CS_N) && k < 1000) begin tick(); k++; end
        check("final_idle", 32'(busy), 32'd0);
        check("sclk_timing", 32'(sclk_bad), 32'd0);
        check("saddr_timing", 32'(saddr_bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
